fill_empty_cell_seq: RTL and testbench

//  Sequential, parametrised tile spawner for the 2048 board. On a start pulse it

---
 rtl/fill_empty_cell_seq.sv | 107 ++++++++++
 tb/tb_fill_empty_cell_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_empty_cell_seq.sv
// Purpose: spawn one new tile into the first empty board cell found by a wrap-around scan from a random start index.
// Latency: empty cell at scan offset k -> calc_done in cycle k+2 after the start cycle; full board -> cycle N_CELLS+1.
// Backpressure: none; start is accepted only in IDLE, and a start seen while scanning or done is dropped rather than queued.
module fill_empty_cell_seq #(
    parameter int N_CELLS     = 16,
    parameter int CELL_W      = 5,
    parameter int POS_W       = 4,
    parameter int PROB_W      = 6,
    parameter int PROB_THRESH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_CELLS*CELL_W-1:0] cell_all_in,
    input  logic [POS_W-1:0]          random_pos,
    input  logic [PROB_W-1:0]         random_prob,
    output logic [N_CELLS*CELL_W-1:0] cell_all_out,
    output logic [POS_W-1:0]          filled_pos,
    output logic                      full,
    output logic                      busy,
    output logic                      calc_done
);

    localparam int CNT_W = $clog2(N_CELLS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    logic [N_CELLS*CELL_W-1:0]   snap;
    logic [PROB_W-1:0]           prob_q;
    logic [POS_W-1:0]            idx;
    logic [CNT_W-1:0]            count;

    logic [CELL_W-1:0]           cur_cell;
    logic [CELL_W-1:0]           tile;
    logic [N_CELLS*CELL_W-1:0]   filled_board;

    // Current scan cell, the tile to spawn, and the snapshot with that tile dropped into idx.
    always_comb begin
        cur_cell     = snap[idx*CELL_W +: CELL_W];
        tile         = (int'(prob_q) < PROB_THRESH) ? CELL_W'(2) : CELL_W'(1);
        filled_board = snap;
        filled_board[idx*CELL_W +: CELL_W] = tile;
    end

    // Control FSM with all outputs registered; results only change on the transition into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            snap         <= '0;
            prob_q       <= '0;
            idx          <= '0;
            count        <= '0;
            cell_all_out <= '0;
            filled_pos   <= '0;
            full         <= 1'b0;
            busy         <= 1'b0;
            calc_done    <= 1'b0;
        end else begin
            calc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap   <= cell_all_in;
                        prob_q <= random_prob;
                        idx    <= POS_W'(int'(random_pos) % N_CELLS);
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_cell == '0) begin
                        cell_all_out <= filled_board;
                        filled_pos   <= idx;
                        full         <= 1'b0;
                        busy         <= 1'b0;
                        calc_done    <= 1'b1;
                        state        <= DONE;
                    end else if (count == CNT_W'(N_CELLS - 1)) begin
                        // Every cell has now been seen occupied: report full, board unchanged.
                        cell_all_out <= snap;
                        filled_pos   <= '0;
                        full         <= 1'b1;
                        busy         <= 1'b0;
                        calc_done    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        idx   <= (idx == POS_W'(N_CELLS - 1)) ? '0 : idx + 1'b1;
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fill_empty_cell_seq.sv
// Purpose: directed self-checking bench for the tile spawner, default 16-cell and a 25-cell instance.
// Latency: done cycle is counted from the start-sampling edge (cycle 0).
// Backpressure: not applicable; bench drives start pulses and observes outputs #1 after each edge.
module tb_fill_empty_cell_seq;

    localparam int NA = 16, WA = 5, PA = 4, RW = 6;
    localparam int NB = 25, WB = 6, PB = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               start_a, start_b;
    logic [NA*WA-1:0]   in_a, out_a;
    logic [NB*WB-1:0]   in_b, out_b;
    logic [PA-1:0]      pos_a, fpos_a;
    logic [PB-1:0]      pos_b, fpos_b;
    logic [RW-1:0]      prob_a, prob_b;
    logic               full_a, busy_a, done_a;
    logic               full_b, busy_b, done_b;

    fill_empty_cell_seq u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cell_all_in(in_a),
        .random_pos(pos_a), .random_prob(prob_a), .cell_all_out(out_a),
        .filled_pos(fpos_a), .full(full_a), .busy(busy_a), .calc_done(done_a)
    );

    fill_empty_cell_seq #(.N_CELLS(NB), .CELL_W(WB), .POS_W(PB)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cell_all_in(in_b),
        .random_pos(pos_b), .random_prob(prob_b), .cell_all_out(out_b),
        .filled_pos(fpos_b), .full(full_b), .busy(busy_b), .calc_done(done_b)
    );

    int checks = 0;
    int passes = 0;

    logic [NA*WA-1:0] board1, board_full;

    function automatic logic [NA*WA-1:0] set_a(input logic [NA*WA-1:0] b, input int i, input logic [WA-1:0] v);
        logic [NA*WA-1:0] r;
        r = b;
        r[i*WA +: WA] = v;
        return r;
    endfunction

    function automatic logic [NB*WB-1:0] set_b(input logic [NB*WB-1:0] b, input int i, input logic [WB-1:0] v);
        logic [NB*WB-1:0] r;
        r = b;
        r[i*WB +: WB] = v;
        return r;
    endfunction

    // Issue one request on instance A and wait (bounded) for calc_done.
    task automatic req_a(input logic [NA*WA-1:0] board, input logic [PA-1:0] pos, input logic [RW-1:0] prob,
                         output int done_cyc, output int busy_cyc);
        in_a = board; pos_a = pos; prob_a = prob; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        done_cyc = -1;
        busy_cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            if (busy_a) busy_cyc++;
            if (done_a) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_a, fpos_a, full_a, busy_a, done_a} !== '0) $display("FAIL reset_a: got out=%h pos=%0d full=%b busy=%b done=%b, want all 0", out_a, fpos_a, full_a, busy_a, done_a);
        else passes++;
        checks++;
        if ({out_b, fpos_b, full_b, busy_b, done_b} !== '0) $display("FAIL reset_b: got out=%h pos=%0d full=%b busy=%b done=%b, want all 0", out_b, fpos_b, full_b, busy_b, done_b);
        else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int dc, bc;
        logic [NA*WA-1:0] exp_b;
        req_a(board1, 4'd10, 6'd1, dc, bc);
        exp_b = set_a(board1, 0, 5'd2);
        checks++;
        if (dc !== 8) $display("FAIL wrap_done_cycle: got %0d, want 8", dc); else passes++;
        checks++;
        if (fpos_a !== 4'd0 || full_a !== 1'b0) $display("FAIL wrap_pos: got pos=%0d full=%b, want pos=0 full=0", fpos_a, full_a); else passes++;
        checks++;
        if (out_a !== exp_b) $display("FAIL wrap_board: got %h, want %h", out_a, exp_b); else passes++;
        @(posedge clk); #1;
        checks++;
        if (done_a !== 1'b0 || out_a !== exp_b) $display("FAIL wrap_hold: got done=%b out=%h, want done=0 out=%h", done_a, out_a, exp_b); else passes++;
    endtask

    task automatic test_first_empty();
        int dc, bc;
        logic [NA*WA-1:0] exp_b;
        req_a(board1, 4'd1, 6'd40, dc, bc);
        exp_b = set_a(board1, 1, 5'd1);
        checks++;
        if (dc !== 2 || bc !== 1) $display("FAIL direct_timing: got done=%0d busy_cycles=%0d, want 2 and 1", dc, bc); else passes++;
        checks++;
        if (fpos_a !== 4'd1 || out_a !== exp_b) $display("FAIL direct_result: got pos=%0d out=%h, want pos=1 out=%h", fpos_a, out_a, exp_b); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        int dc, bc;
        req_a(board_full, 4'd5, 6'd0, dc, bc);
        checks++;
        if (dc !== 17 || bc !== 16) $display("FAIL full_timing: got done=%0d busy_cycles=%0d, want 17 and 16", dc, bc); else passes++;
        checks++;
        if (full_a !== 1'b1 || fpos_a !== 4'd0 || out_a !== board_full) $display("FAIL full_result: got full=%b pos=%0d out=%h, want full=1 pos=0 out=%h", full_a, fpos_a, out_a, board_full); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_offset4();
        int dc, bc;
        req_a(board1, 4'd12, 6'd63, dc, bc);
        checks++;
        if (dc !== 6 || fpos_a !== 4'd0 || out_a !== set_a(board1, 0, 5'd1)) $display("FAIL offset4: got done=%0d pos=%0d out=%h, want done=6 pos=0", dc, fpos_a, out_a); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int dc;
        int extra;
        in_a = board1; pos_a = 4'd10; prob_a = 6'd1; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        dc = -1;
        for (int c = 1; c <= 100; c++) begin
            if (c == 2) begin
                start_a = 1'b1; pos_a = 4'd1; prob_a = 6'd40; in_a = board_full;
            end
            if (c == 3) start_a = 1'b0;
            if (done_a) begin
                dc = c;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (dc !== 8 || fpos_a !== 4'd0 || out_a !== set_a(board1, 0, 5'd2)) $display("FAIL start_ignored: got done=%0d pos=%0d out=%h, want done=8 pos=0 cell0=2", dc, fpos_a, out_a); else passes++;
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_a) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL start_not_queued: got %0d extra done pulses, want 0", extra); else passes++;
    endtask

    task automatic test_reset_mid_scan();
        int pulses, dc, bc;
        in_a = board_full; pos_a = 4'd3; prob_a = 6'd0; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_a, fpos_a, full_a, busy_a, done_a} !== '0) $display("FAIL midscan_reset: got out=%h pos=%0d full=%b busy=%b done=%b, want all 0", out_a, fpos_a, full_a, busy_a, done_a); else passes++;
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_a) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL midscan_no_done: got %0d pulses, want 0", pulses); else passes++;
        req_a(board1, 4'd1, 6'd40, dc, bc);
        checks++;
        if (dc !== 2 || fpos_a !== 4'd1 || out_a !== set_a(board1, 1, 5'd1)) $display("FAIL after_reset_req: got done=%0d pos=%0d out=%h, want done=2 pos=1", dc, fpos_a, out_a); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_big_grid();
        logic [NB*WB-1:0] bb;
        int dc;
        bb = '0;
        for (int i = 2; i < NB; i++) bb = set_b(bb, i, 6'd3);
        // 27 mod 25 = 2: scan 2..24, wrap to 0 at offset 23.
        in_b = bb; pos_b = 5'd27; prob_b = 6'd10; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        dc = -1;
        for (int c = 1; c <= 100; c++) begin
            if (done_b) begin
                dc = c;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (dc !== 25 || fpos_b !== 5'd0 || full_b !== 1'b0 || out_b !== set_b(bb, 0, 6'd1)) $display("FAIL big_wrap: got done=%0d pos=%0d full=%b out=%h, want done=25 pos=0 cell0=1", dc, fpos_b, full_b, out_b); else passes++;
        @(posedge clk); #1;
        bb = set_b(bb, 2, 6'd0);
        in_b = bb; pos_b = 5'd27; prob_b = 6'd3; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        dc = -1;
        for (int c = 1; c <= 100; c++) begin
            if (done_b) begin
                dc = c;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (dc !== 2 || fpos_b !== 5'd2 || out_b !== set_b(bb, 2, 6'd2)) $display("FAIL big_modulo: got done=%0d pos=%0d out=%h, want done=2 pos=2 cell2=2", dc, fpos_b, out_b); else passes++;
        @(posedge clk); #1;
    endtask

    initial begin
        start_a = 1'b0; start_b = 1'b0;
        in_a = '0; in_b = '0; pos_a = '0; pos_b = '0; prob_a = '0; prob_b = '0;
        board1 = '0;
        for (int i = 3; i < NA; i++) board1 = set_a(board1, i, 5'd1);
        board_full = '0;
        for (int i = 0; i < NA; i++) board_full = set_a(board_full, i, 5'd1);

        test_reset();
        test_wrap();
        test_first_empty();
        test_full();
        test_offset4();
        test_start_ignored();
        test_reset_mid_scan();
        test_big_grid();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
